// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential bit-sliced ALU: op codes and FSM states.
package alu_seq_pkg;

  localparam logic [1:0] OP_LUT = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_INC = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice: ripple adder for ADD/SUB/INC, per-bit
// truth-table lookup for LUT. c_msb_in exposes the carry into the slice MSB
// so the caller can derive signed overflow on the top slice.
module alu_slice
  import alu_seq_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [1:0]       op,
  input  logic [3:0]       lut,
  input  logic             cin,
  output logic [SLICE-1:0] y,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SLICE-1:0] b_eff;
  logic             c;

  // Ripple through the slice, or look each bit up when op is LUT
  always_comb begin
    y        = '0;
    cout     = 1'b0;
    c_msb_in = 1'b0;
    c        = cin;
    b_eff    = b;
    if (op == OP_SUB) begin
      b_eff = ~b;
    end else if (op == OP_INC) begin
      b_eff = '0;
    end
    if (op == OP_LUT) begin
      // No carry chain at all: the carry register stays cleared for LUT ops
      for (int i = 0; i < SLICE; i++) begin
        y[i] = lut[{a[i], b[i]}];
      end
    end else begin
      for (int i = 0; i < SLICE; i++) begin
        if (i == SLICE - 1) begin
          c_msb_in = c;
        end
        y[i] = a[i] ^ b_eff[i] ^ c;
        c    = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
      end
      cout = c;
    end
  end

endmodule

// File: rtl/alu_seq_slice.sv
// Multi-cycle bit-sliced ALU: one SLICE-bit slice per clock with the carry
// held between slices; valid/ready handshakes on operands and result.
module alu_seq_slice
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic [3:0]       in_lut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  logic [1:0]       op_q;
  logic [3:0]       lut_q;
  logic             c_q, v_q;

  logic [SLICE-1:0] s_y;
  logic             s_cout, s_cmsb;
  logic             last_slice;

  assign last_slice = (cnt_q == LAST_CNT);

  // A single slice is time-shared; cnt selects which operand bits feed it
  alu_slice #(.SLICE(SLICE)) u_slice (
    .a        (a_q[cnt_q*SLICE +: SLICE]),
    .b        (b_q[cnt_q*SLICE +: SLICE]),
    .op       (op_q),
    .lut      (lut_q),
    .cin      (carry_q),
    .y        (s_y),
    .cout     (s_cout),
    .c_msb_in (s_cmsb)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; handshakes depend on state only
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-slice result write-back and flag latching
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_LUT;
      lut_q   <= '0;
      y_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        a_q     <= in_a;
        b_q     <= in_b;
        op_q    <= in_op;
        lut_q   <= in_lut;
        cnt_q   <= '0;
        // SUB adds ~b + 1, INC adds 0 + 1: the +1 enters as the initial carry
        carry_q <= (in_op == OP_SUB) || (in_op == OP_INC);
      end
    end else if (state_q == RUN) begin
      y_q[cnt_q*SLICE +: SLICE] <= s_y;
      carry_q <= s_cout;
      if (last_slice) begin
        c_q <= s_cout;
        v_q <= s_cmsb ^ s_cout;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_y = y_q;
  assign out_c = c_q;
  assign out_v = v_q;
  // Zero flag only reflects a finished result
  assign out_z = (state_q == DONE) && (y_q == '0);

endmodule

// File: tb/tb_alu_seq_slice.sv
// Self-checking bench for alu_seq_slice (WIDTH=16, SLICE=4): directed vector
// table, backpressure and mid-operation reset sequences, random ops vs model.
module tb_alu_seq_slice;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [1:0]       in_op = 2'd0;
  logic [3:0]       in_lut = 4'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_y;
  logic             out_c, out_v, out_z;

  int checks = 0;
  int errors = 0;

  alu_seq_slice #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_lut    (in_lut),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_c     (out_c),
    .out_v     (out_v),
    .out_z     (out_z)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [3:0]  lut;
    logic [15:0] y;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word arithmetic straight from the op definitions
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic [1:0] op, input logic [3:0] lut,
                                output logic [15:0] y, output logic c,
                                output logic v, output logic z);
    int sa, sb, sr;
    logic [16:0] s;
    y = '0; c = 1'b0; v = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: begin
        for (int i = 0; i < 16; i++) y[i] = lut[{a[i], b[i]}];
      end
      2'd1: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[15:0]; c = s[16];
        sr = sa + sb;
        v = (sr > 32767) || (sr < -32768);
      end
      2'd2: begin
        y = a - b;
        c = (a >= b);
        sr = sa - sb;
        v = (sr > 32767) || (sr < -32768);
      end
      default: begin
        y = a + 16'd1;
        c = (a == 16'hFFFF);
        v = (a == 16'h7FFF);
      end
    endcase
    z = (y == 16'h0000);
  endfunction

  // One full transaction: issue, measure latency, hold off hold cycles, retire
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input logic [3:0] lut,
                       input logic [15:0] ey, input logic ec, input logic ev,
                       input logic ez, input int hold);
    int lat;
    check({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_a = a; in_b = b; in_op = op; in_lut = lut; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, ".latency"}, lat, NSLICE);
    for (int h = 0; h <= hold; h++) begin
      check({name, ".y"}, {16'd0, out_y}, {16'd0, ey});
      check({name, ".cvz"}, {29'd0, out_c, out_v, out_z}, {29'd0, ec, ev, ez});
      if (h < hold) tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, ".retire"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    $display("op=%0d a=%h b=%h lut=%b -> y=%h c=%b v=%b z=%b lat=%0d", op, a, b, lut,
             ey, ec, ev, ez, lat);
  endtask

  initial begin
    logic [15:0] ry, ra, rb, held_y;
    logic        rc, rv, rz;
    logic [1:0]  rop;
    logic [3:0]  rlut;
    logic [2:0]  held_f;
    int          seen;

    vecs[0] = '{16'h00FF, 16'h0001, 2'd1, 4'h0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h8000, 16'h0001, 2'd2, 4'h0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 2'd2, 4'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'hF0F0, 16'hFF00, 2'd0, 4'b0110, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'hF0F0, 16'hFF00, 2'd0, 4'b1000, 16'hF000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h1234, 2'd3, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h7FFF, 16'h0001, 2'd1, 4'h0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'hFFFF, 16'h0001, 2'd1, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{16'h0005, 16'h0005, 2'd2, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{16'h7FFF, 16'h0000, 2'd3, 4'h0, 16'h8000, 1'b0, 1'b1, 1'b0};

    // Reset values
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset.hs", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    check("reset.y", {16'd0, out_y}, 32'd0);
    check("reset.cvz", {29'd0, out_c, out_v, out_z}, 32'd0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].lut,
            vecs[i].y, vecs[i].c, vecs[i].v, vecs[i].z, 0);
    end

    // Backpressure with in_valid toggling while the result is held
    in_a = 16'h1234; in_b = 16'h1111; in_op = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 20) begin tick(); seen++; end
    check("bp.latency", seen, NSLICE);
    held_y = out_y;
    held_f = {out_c, out_v, out_z};
    check("bp.y", {16'd0, out_y}, 32'h2345);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      in_a = $urandom; in_b = $urandom; in_op = 2'($urandom);
      tick();
      check("bp.hold_y", {16'd0, out_y}, {16'd0, held_y});
      check("bp.hold_f", {29'd0, out_c, out_v, out_z}, {29'd0, held_f});
      check("bp.hs", {30'd0, in_ready, out_valid}, {30'd0, 1'b0, 1'b1});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.retire", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    seen = 0;
    for (int k = 0; k < 8; k++) begin tick(); if (out_valid) seen++; end
    check("bp.no_extra", seen, 0);
    $display("backpressure sequence y=%h held 5 cycles", held_y);

    // Reset during RUN with cnt == 2
    in_a = 16'hABCD; in_b = 16'h1357; in_op = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrun.hs", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    check("rstrun.y", {16'd0, out_y}, 32'd0);
    check("rstrun.cvz", {29'd0, out_c, out_v, out_z}, 32'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin tick(); if (out_valid) seen++; end
    check("rstrun.abandoned", seen, 0);
    $display("reset mid-run sequence done");
    do_op("after_rst", 16'h1111, 16'h2222, 2'd1, 4'h0, 16'h3333, 1'b0, 1'b0, 1'b0, 0);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 16'hFFFF - 16'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) rb = ra;
      rop = 2'($urandom_range(0, 3));
      rlut = 4'($urandom);
      model(ra, rb, rop, rlut, ry, rc, rv, rz);
      do_op($sformatf("rnd%0d", i), ra, rb, rop, rlut, ry, rc, rv, rz,
            $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
